// File: rtl/s_memory_shuffle.sv
// RC4 key-scheduling stage: permutes the 256-byte S memory in place using the secret key.
// One iteration reads S[i], updates j, reads S[j], then writes the swapped pair (8 cycles).
module s_memory_shuffle #(
    parameter int unsigned KEY_LENGTH = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [8*KEY_LENGTH-1:0] secret_key,
    input  logic [7:0]              q,
    output logic [7:0]              address,
    output logic [7:0]              data,
    output logic                    wren,
    output logic                    finish
);

    localparam int unsigned KIDX_W = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

    typedef enum logic [3:0] {
        StIdle,
        StRdI,
        StWtI,
        StCalcJ,
        StRdJ,
        StWtJ,
        StLatchJ,
        StWrI,
        StWrJ,
        StFinish
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          i_q, i_d;
    logic [7:0]          j_q, j_d;
    logic [7:0]          si_q, si_d;
    logic [7:0]          sj_q, sj_d;
    logic [KIDX_W-1:0]   kidx_q, kidx_d;
    logic [7:0]          key_byte;

    // Byte 0 of the key sits in the most significant byte of secret_key.
    always_comb begin
        key_byte = '0;
        for (int unsigned k = 0; k < KEY_LENGTH; k++) begin
            if (kidx_q == KIDX_W'(k)) begin
                key_byte = secret_key[8*(KEY_LENGTH-1-k) +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        kidx_d  = kidx_q;
        address = '0;
        data    = '0;
        wren    = 1'b0;
        finish  = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRdI;
                    i_d     = '0;
                    j_d     = '0;
                    kidx_d  = '0;
                end
            end
            StRdI: begin
                address = i_q;
                state_d = StWtI;
            end
            StWtI: begin
                address = i_q;
                state_d = StCalcJ;
            end
            StCalcJ: begin
                address = i_q;
                si_d    = q;
                j_d     = j_q + q + key_byte;
                state_d = StRdJ;
            end
            StRdJ: begin
                address = j_q;
                state_d = StWtJ;
            end
            StWtJ: begin
                address = j_q;
                state_d = StLatchJ;
            end
            StLatchJ: begin
                address = j_q;
                sj_d    = q;
                state_d = StWrI;
            end
            StWrI: begin
                address = i_q;
                data    = sj_q;
                wren    = 1'b1;
                state_d = StWrJ;
            end
            StWrJ: begin
                address = j_q;
                data    = si_q;
                wren    = 1'b1;
                if (i_q == 8'd255) begin
                    state_d = StFinish;
                end else begin
                    i_d     = i_q + 8'd1;
                    kidx_d  = (kidx_q == KIDX_W'(KEY_LENGTH - 1)) ? '0 : kidx_q + KIDX_W'(1);
                    state_d = StRdI;
                end
            end
            StFinish: begin
                finish  = 1'b1;
                i_d     = '0;
                j_d     = '0;
                kidx_d  = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            kidx_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            kidx_q  <= kidx_d;
        end
    end

endmodule

// File: tb/tb_s_memory_shuffle.sv
// Bench for s_memory_shuffle: S memory model, software KSA reference, timing and reset checks.
module tb_s_memory_shuffle;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  q;
    logic [7:0]  address;
    logic [7:0]  data;
    logic        wren;
    logic        finish;

    s_memory_shuffle #(.KEY_LENGTH(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .secret_key (secret_key),
        .q          (q),
        .address    (address),
        .data       (data),
        .wren       (wren),
        .finish     (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory with registered read; preload restores S[k]=k.
    logic [7:0] mem [256];
    logic       preload;
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else if (wren) begin
            mem[address] <= data;
        end
        q <= mem[address];
    end

    int unsigned cyc;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] wq[$];
    int unsigned fin_q[$];
    always @(negedge clk) begin
        if (wren) wq.push_back({address, data});
        if (finish) fin_q.push_back(cyc);
    end

    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference KSA: expected write stream (pre-swap values) and final permutation.
    logic [15:0] exp_w [512];
    logic [7:0]  exp_s [256];
    function automatic void ksa_model(input logic [23:0] key);
        int s[256];
        int kb[3];
        int j;
        int t;
        kb[0] = int'(key[23:16]);
        kb[1] = int'(key[15:8]);
        kb[2] = int'(key[7:0]);
        for (int k = 0; k < 256; k++) s[k] = k;
        j = 0;
        for (int i = 0; i < 256; i++) begin
            j = (j + s[i] + kb[i % 3]) % 256;
            exp_w[2*i]   = {8'(i), 8'(s[j])};
            exp_w[2*i+1] = {8'(j), 8'(s[i])};
            t = s[i]; s[i] = s[j]; s[j] = t;
        end
        for (int k = 0; k < 256; k++) exp_s[k] = 8'(s[k]);
    endfunction

    task automatic do_preload();
        @(negedge clk);
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
    endtask

    int unsigned cn;
    int          last_wbase;

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cn = cyc;
    endtask

    task automatic run_and_check(input logic [23:0] key, input int glitch_at, input string tag);
        int wbase;
        int fbase;
        int guard;
        int mism;
        int lat;
        do_preload();
        secret_key = key;
        ksa_model(key);
        wbase = wq.size();
        fbase = fin_q.size();
        last_wbase = wbase;
        pulse_start();
        if (glitch_at > 0) begin
            repeat (glitch_at) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        guard = 0;
        while (fin_q.size() == fbase && guard < 2300) begin
            @(negedge clk);
            #1 guard++;
        end
        repeat (4) @(negedge clk);
        #1;
        lat = (fin_q.size() > fbase) ? int'(fin_q[fbase] - cn) : -1;
        check({tag, " finish_latency"}, lat, 2048);
        check({tag, " finish_pulses"}, fin_q.size() - fbase, 1);
        check({tag, " write_count"}, wq.size() - wbase, 512);
        mism = 0;
        if (wq.size() >= wbase + 512) begin
            for (int w = 0; w < 512; w++) if (wq[wbase+w] !== exp_w[w]) mism++;
        end else begin
            mism = 512;
        end
        check({tag, " write_seq_mismatches"}, mism, 0);
        mism = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== exp_s[k]) mism++;
        check({tag, " final_s_mismatches"}, mism, 0);
    endtask

    typedef struct {
        logic [23:0] key;
        logic [31:0] addrs;
        logic [31:0] datas;
    } vec_t;
    vec_t vecs[4];

    initial begin
        int wb;
        int guard;
        int fb;
        logic [31:0] a;
        logic [31:0] d;
        logic [15:0] got;

        // First four writes hand-derived from the KSA rules (iterations 0 and 1).
        vecs[0] = '{key: 24'h000000, addrs: 32'h00000101, datas: 32'h00000101};
        vecs[1] = '{key: 24'h4A7B1C, addrs: 32'h004A01C6, datas: 32'h4A00C601};
        vecs[2] = '{key: 24'h010203, addrs: 32'h00010103, datas: 32'h01000300};
        vecs[3] = '{key: 24'hFFFFFF, addrs: 32'h00FF01FF, datas: 32'hFF000001};

        n_checks   = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        start      = 1'b0;
        preload    = 1'b0;
        secret_key = '0;
        #1;
        check("reset address", address, 0);
        check("reset data", data, 0);
        check("reset wren", wren, 0);
        check("reset finish", finish, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        for (int t = 0; t < 4; t++) begin
            run_and_check(vecs[t].key, 0, $sformatf("vec%0d", t));
            a = vecs[t].addrs;
            d = vecs[t].datas;
            for (int w = 0; w < 4; w++) begin
                got = (wq.size() > last_wbase + w) ? wq[last_wbase+w] : 16'hxxxx;
                check($sformatf("vec%0d first_write%0d", t, w), got,
                      {a[31-8*w -: 8], d[31-8*w -: 8]});
            end
        end

        for (int r = 0; r < 3; r++) begin
            run_and_check(24'($urandom), 0, $sformatf("rand%0d", r));
        end

        // Reset asserted in the WR_I cycle of iteration 100.
        do_preload();
        secret_key = 24'($urandom);
        pulse_start();
        repeat (806) @(posedge clk);
        #2;
        check("midrun wren_before_reset", wren, 1);
        check("midrun address_before_reset", address, 100);
        reset_n = 1'b0;
        #1;
        check("midrun reset address", address, 0);
        check("midrun reset data", data, 0);
        check("midrun reset wren", wren, 0);
        check("midrun reset finish", finish, 0);
        wb = wq.size();
        fb = fin_q.size();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check("post_reset writes", wq.size() - wb, 0);
        check("post_reset finishes", fin_q.size() - fb, 0);
        run_and_check(24'h4A7B1C, 0, "after_reset");

        // Start pulsed during iteration 10 must be ignored.
        run_and_check(24'($urandom), 80, "busy_start");

        // Start held high: back-to-back runs every 2050 cycles.
        fb = fin_q.size();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 cn = cyc;
        guard = 0;
        while (fin_q.size() < fb + 3 && guard < 7000) begin
            @(negedge clk);
            #1 guard++;
        end
        start = 1'b0;
        check("held finishes", fin_q.size() - fb, 3);
        if (fin_q.size() >= fb + 3) begin
            check("held first_latency", fin_q[fb] - cn, 2048);
            check("held period1", fin_q[fb+1] - fin_q[fb], 2050);
            check("held period2", fin_q[fb+2] - fin_q[fb+1], 2050);
        end
        repeat (10) @(negedge clk);
        #1;
        check("held stops_after_release", fin_q.size() - fb, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
